// File: rtl/cnn_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_div_pkg
// Description : Shared widths, FSM state type and quotient saturation helper
//               for the sequential signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_div_pkg;

    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W  = 14;
    localparam int QUOT_W     = 10;
    localparam int PREM_W     = DIVISOR_W + 1;
    localparam int CNT_W      = $clog2(DIVIDEND_W);

    localparam logic signed [QUOT_W-1:0] QMAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic signed [QUOT_W-1:0] QMIN = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    typedef struct packed {
        logic signed [QUOT_W-1:0] q;
        logic                     sat;
    } qsat_t;

    // Clip the full-width signed quotient into the output range.
    function automatic qsat_t saturate_q(input logic signed [DIVIDEND_W:0] v);
        qsat_t res;
        if (v > (DIVIDEND_W+1)'(QMAX)) begin
            res.q   = QMAX;
            res.sat = 1'b1;
        end else if (v < (DIVIDEND_W+1)'(QMIN)) begin
            res.q   = QMIN;
            res.sat = 1'b1;
        end else begin
            res.q   = v[QUOT_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_sdiv_step.sv
`default_nettype none
// ============================================================================
// Module      : cnn_sdiv_step
// Description : One combinational restoring-division step on magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_sdiv_step
    import cnn_div_pkg::*;
(
    input  logic [PREM_W-1:0]    prem,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] dmag,
    output logic [PREM_W-1:0]    prem_next,
    output logic                 q_bit
);

    logic [PREM_W:0] w_shift;
    logic [PREM_W:0] w_diff;

    // The shifted remainder stays below 2^PREM_W, so the top bit of the
    // one-bit-wider difference is exactly the borrow of the trial subtract.
    assign w_shift   = {prem, next_bit};
    assign w_diff    = w_shift - {2'b00, dmag};
    assign q_bit     = ~w_diff[PREM_W];
    assign prem_next = q_bit ? w_diff[PREM_W-1:0] : w_shift[PREM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/cnn_sdiv_24s_14s_10s_seq.sv
`default_nettype none
// ============================================================================
// Module      : cnn_sdiv_24s_14s_10s_seq
// Description : Sequential signed restoring divider, 24s / 14s -> saturated
//               10s quotient and 14s remainder, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_sdiv_24s_14s_10s_seq
    import cnn_div_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  sat,
    output logic                  div_zero
);

    div_state_t r_state;
    div_state_t w_state_next;

    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVIDEND_W-1:0] r_mq;
    logic [DIVISOR_W-1:0]  r_dmag;
    logic [PREM_W-1:0]     r_pr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic                  r_dz;

    logic [QUOT_W-1:0]     r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_sat;
    logic                  r_div_zero;

    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dsr_mag;
    logic [PREM_W-1:0]     w_pr_next;
    logic                  w_qbit;

    logic signed [DIVIDEND_W:0]  w_mag_q;
    logic signed [DIVIDEND_W:0]  w_q_full;
    logic signed [DIVISOR_W-1:0] w_mag_r;
    logic signed [DIVISOR_W-1:0] w_rem_s;
    qsat_t                       w_qs;

    // Two's-complement negate of the most negative dividend yields 2^23,
    // which is exact when read back as unsigned.
    assign w_dvd_mag = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    assign w_dsr_mag = divisor[DIVISOR_W-1]   ? -divisor  : divisor;

    cnn_sdiv_step u_step (
        .prem      (r_pr),
        .next_bit  (r_dvd[DIVIDEND_W-1]),
        .dmag      (r_dmag),
        .prem_next (w_pr_next),
        .q_bit     (w_qbit)
    );

    assign w_mag_q  = {1'b0, r_mq};
    assign w_q_full = (r_sign_a ^ r_sign_b) ? -w_mag_q : w_mag_q;
    assign w_mag_r  = r_pr[DIVISOR_W-1:0];
    assign w_rem_s  = r_sign_a ? -w_mag_r : w_mag_r;
    assign w_qs     = saturate_q(w_q_full);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)      w_state_next = CALC;
            CALC:    if (r_cnt == '0)   w_state_next = FIX;
            FIX:                        w_state_next = DONE;
            DONE:    if (out_ready)     w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_dvd      <= '0;
            r_mq       <= '0;
            r_dmag     <= '0;
            r_pr       <= '0;
            r_cnt      <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_dz       <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_sat      <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dvd    <= w_dvd_mag;
                        r_mq     <= '0;
                        r_dmag   <= w_dsr_mag;
                        r_pr     <= '0;
                        r_cnt    <= CNT_W'(DIVIDEND_W - 1);
                        r_sign_a <= dividend[DIVIDEND_W-1];
                        r_sign_b <= divisor[DIVISOR_W-1];
                        r_dz     <= (divisor == '0);
                    end
                end
                CALC: begin
                    r_pr  <= w_pr_next;
                    r_mq  <= {r_mq[DIVIDEND_W-2:0], w_qbit};
                    r_dvd <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    // A zero divisor still walks the full CALC sequence so
                    // latency is constant; its datapath result is discarded.
                    if (r_dz) begin
                        r_quot     <= r_sign_a ? QMIN : QMAX;
                        r_rem      <= '0;
                        r_sat      <= 1'b1;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_quot     <= w_qs.q;
                        r_rem      <= w_rem_s;
                        r_sat      <= w_qs.sat;
                        r_div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign sat       = r_sat;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_cnn_sdiv_24s_14s_10s_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_sdiv_24s_14s_10s_seq
// Description : Directed self-checking bench for the sequential signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_sdiv_24s_14s_10s_seq;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [23:0]        dividend;
    logic [13:0]        divisor;
    logic               out_valid;
    logic               out_ready;
    logic signed [9:0]  quotient;
    logic signed [13:0] remainder;
    logic               sat;
    logic               div_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    cnn_sdiv_24s_14s_10s_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .sat       (sat),
        .div_zero  (div_zero)
    );

    // Issue one operation and return the number of edges from accept to out_valid.
    task automatic run_op(input int a, input int b, output int lat);
        int guard;
        guard = 0;
        @(negedge ap_clk);
        while (!in_ready && guard < 100) begin
            @(negedge ap_clk);
            guard++;
        end
        dividend = 24'(a);
        divisor  = 14'(b);
        in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        lat = 0;
        while (lat < 100) begin
            @(posedge ap_clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic release_result();
        @(negedge ap_clk);
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (quotient !== 10'sd0) begin n_err++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
        n_cmp++; if (remainder !== 14'sd0) begin n_err++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
        n_cmp++; if ({sat, div_zero} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", sat, div_zero); end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_signs();
        int a  [4] = '{1000, -1000, 1000, -1000};
        int b  [4] = '{7, 7, -7, -7};
        int eq [4] = '{142, -142, -142, 142};
        int er [4] = '{6, -6, 6, -6};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(a[i], b[i], lat);
            n_cmp++; if (lat !== 25) begin n_err++; $display("FAIL signs_latency[%0d]: got %0d want 25", i, lat); end
            n_cmp++; if (quotient !== eq[i]) begin n_err++; $display("FAIL signs_quotient[%0d]: got %0d want %0d", i, quotient, eq[i]); end
            n_cmp++; if (remainder !== er[i]) begin n_err++; $display("FAIL signs_remainder[%0d]: got %0d want %0d", i, remainder, er[i]); end
            n_cmp++; if ({sat, div_zero} !== 2'b00) begin n_err++; $display("FAIL signs_flags[%0d]: got %b%b want 00", i, sat, div_zero); end
            release_result();
        end
    endtask

    task automatic test_saturation();
        int a  [2] = '{100000, -8388608};
        int b  [2] = '{-3, -8192};
        int eq [2] = '{-512, 511};
        int er [2] = '{1, 0};
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_op(a[i], b[i], lat);
            n_cmp++; if (lat !== 25) begin n_err++; $display("FAIL sat_latency[%0d]: got %0d want 25", i, lat); end
            n_cmp++; if (quotient !== eq[i]) begin n_err++; $display("FAIL sat_quotient[%0d]: got %0d want %0d", i, quotient, eq[i]); end
            n_cmp++; if (remainder !== er[i]) begin n_err++; $display("FAIL sat_remainder[%0d]: got %0d want %0d", i, remainder, er[i]); end
            n_cmp++; if ({sat, div_zero} !== 2'b10) begin n_err++; $display("FAIL sat_flags[%0d]: got %b%b want 10", i, sat, div_zero); end
            release_result();
        end
    endtask

    task automatic test_div_zero();
        int a  [3] = '{5, -5, 0};
        int eq [3] = '{511, -512, 511};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(a[i], 0, lat);
            n_cmp++; if (lat !== 25) begin n_err++; $display("FAIL dz_latency[%0d]: got %0d want 25", i, lat); end
            n_cmp++; if (quotient !== eq[i]) begin n_err++; $display("FAIL dz_quotient[%0d]: got %0d want %0d", i, quotient, eq[i]); end
            n_cmp++; if (remainder !== 14'sd0) begin n_err++; $display("FAIL dz_remainder[%0d]: got %0d want 0", i, remainder); end
            n_cmp++; if ({sat, div_zero} !== 2'b11) begin n_err++; $display("FAIL dz_flags[%0d]: got %b%b want 11", i, sat, div_zero); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(1000, 7, lat);
        for (int k = 0; k < 10; k++) begin
            @(negedge ap_clk);
            n_cmp++;
            if ({out_valid, in_ready, quotient, remainder, sat, div_zero} !==
                {1'b1, 1'b0, 10'sd142, 14'sd6, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL hold_cycle[%0d]: got v=%b rdy=%b q=%0d r=%0d s=%b dz=%b want v=1 rdy=0 q=142 r=6 s=0 dz=0",
                         k, out_valid, in_ready, quotient, remainder, sat, div_zero);
            end
        end
        @(negedge ap_clk);
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL take_to_idle: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        run_op(-1000, -7, lat);
        n_cmp++; if (lat !== 25) begin n_err++; $display("FAIL second_latency: got %0d want 25", lat); end
        n_cmp++; if (quotient !== 10'sd142) begin n_err++; $display("FAIL second_quotient: got %0d want 142", quotient); end
        n_cmp++; if (remainder !== -14'sd6) begin n_err++; $display("FAIL second_remainder: got %0d want -6", remainder); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int  acc_cyc [2] = '{0, 0};
        int  n_acc = 0;
        int  cyc = 0;
        int  guard = 0;
        logic acc;
        @(negedge ap_clk);
        dividend  = 24'(1000);
        divisor   = 14'(7);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (n_acc < 2 && cyc < 100) begin
            acc = in_ready;
            @(posedge ap_clk);
            cyc++;
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge ap_clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (n_acc != 2 || (acc_cyc[1] - acc_cyc[0]) != 27) begin
            n_err++;
            $display("FAIL throughput: got accepts=%0d spacing=%0d want accepts=2 spacing=27", n_acc, acc_cyc[1] - acc_cyc[0]);
        end
        while (!out_valid && guard < 40) begin
            @(posedge ap_clk);
            #1;
            guard++;
        end
        n_cmp++;
        if (out_valid !== 1'b1 || quotient !== 10'sd142 || remainder !== 14'sd6) begin
            n_err++;
            $display("FAIL b2b_result: got v=%b q=%0d r=%0d want v=1 q=142 r=6", out_valid, quotient, remainder);
        end
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        int guard = 0;
        int lat;
        @(negedge ap_clk);
        while (!in_ready && guard < 100) begin
            @(negedge ap_clk);
            guard++;
        end
        dividend = 24'(-1000);
        divisor  = 14'(3);
        in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge ap_clk);
        #3;
        ap_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, sat, div_zero} !==
            {1'b1, 1'b0, 10'sd0, 14'sd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL abort_reset: got rdy=%b v=%b q=%0d r=%0d s=%b dz=%b want rdy=1 v=0 q=0 r=0 s=0 dz=0",
                     in_ready, out_valid, quotient, remainder, sat, div_zero);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_release_ready: got %b want 1", in_ready); end
        run_op(1000, 7, lat);
        n_cmp++; if (lat !== 25) begin n_err++; $display("FAIL abort_next_latency: got %0d want 25", lat); end
        n_cmp++; if (quotient !== 10'sd142) begin n_err++; $display("FAIL abort_next_quotient: got %0d want 142", quotient); end
        n_cmp++; if (remainder !== 14'sd6) begin n_err++; $display("FAIL abort_next_remainder: got %0d want 6", remainder); end
        n_cmp++; if ({sat, div_zero} !== 2'b00) begin n_err++; $display("FAIL abort_next_flags: got %b%b want 00", sat, div_zero); end
        release_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_signs();
        test_saturation();
        test_div_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
